branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped predictor entries; SHALL be a power of two, 4..256.
REQ-002 Parameter ADDR_W, default 32, width of PC and target fields.
REQ-003 Parameter CNT_W, default 32, width of each statistics counter.
REQ-004 The interface SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 pc_i  input  ADDR_W  IF-stage fetch address for lookup.
REQ-008 pred_taken_o  output  1  predict taken for pc_i.
REQ-009 pred_target_o  output  ADDR_W  predicted target; 0 when pred_taken_o=0.
REQ-010 upd_valid_i  input  1  resolved branch/jump reported this cycle.
REQ-011 upd_pc_i  input  ADDR_W  address of the resolved instruction.
REQ-012 upd_taken_i  input  1  actual outcome.
REQ-013 upd_target_i  input  ADDR_W  actual target; meaningful when upd_taken_i=1.
REQ-014 upd_pred_taken_i, upd_pred_target_i  input  1, ADDR_W  prediction that was made for this instruction, carried down the pipe.
REQ-015 clear_i  input  1  synchronous invalidate of all entries.
REQ-016 mispredict_o  output  1  combinational; resolved outcome differs from carried prediction; drives the IF/ID flush.
REQ-017 branch_cnt_o, mispred_cnt_o  output  CNT_W  statistics counters.

Function
REQ-018 Index = pc[IDX_W+1:2], IDX_W=log2(ENTRIES); tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-019 Each entry holds valid bit, tag, target, 2-bit counter with states SNT=00, WNT=01, WT=10, ST=11.
REQ-020 Lookup combinational, zero latency: hit = valid && tag match; pred_taken_o = hit && counter[1]; pred_target_o = stored target when pred_taken_o.
REQ-021 mispredict_o = upd_valid_i && (upd_taken_i != upd_pred_taken_i || (upd_taken_i && upd_target_i != upd_pred_target_i)); 0 when upd_valid_i=0.
REQ-022 Update on hit: taken -> counter increments, saturating at ST, target overwritten with upd_target_i; not taken -> counter decrements, saturating at SNT, target kept.
REQ-023 Update on miss, taken: allocate (overwrite any valid entry at that index), valid=1, tag written, target written, counter=WT.
REQ-024 Update on miss, not taken: no state change.
REQ-025 Lookup and update to the same index in the same cycle: lookup returns the pre-update contents; new contents visible next cycle.
REQ-026 clear_i: all valid bits 0 next edge; clear_i wins over a simultaneous update (update discarded); statistics counters unaffected.
REQ-027 branch_cnt_o increments on each upd_valid_i cycle; mispred_cnt_o increments when mispredict_o=1; both saturate at all-ones, no wrap.
REQ-028 Update is accepted every cycle; no backpressure, no stall output.

Reset
REQ-029 rst_i asserted: all valid bits 0, all counters SNT, tags/targets 0, branch_cnt_o=0, mispred_cnt_o=0, immediately and asynchronously.
REQ-030 During and immediately after reset pred_taken_o=0, pred_target_o=0 for any pc_i; mispredict_o depends only on inputs.
REQ-031 Reset asserted mid-update: update lost; no partial entry written.

Structure
REQ-032 Shared package bp_pkg SHALL hold counter state constants (SNT/WNT/WT/ST), default ENTRIES, and the entry record typedef.
REQ-033 Saturating 2-bit counter SHALL be a sub-module, sat_counter2 (inputs inc/dec/load, output state); the predictor SHALL be the sole instantiator.

Verification
REQ-034 Reset, pc_i=0x40 -> pred_taken_o=0, pred_target_o=0, both stats 0.
REQ-035 Update pc=0x40 taken target 0x80 (pred 0) -> mispredict_o=1, next cycle lookup 0x40 gives taken/0x80, mispred_cnt=1, branch_cnt=1.
REQ-036 Three not-taken updates at 0x40 after REQ-035 -> counter WT->WNT->SNT->SNT, pred_taken_o=0 after first; four taken -> ST, holds.
REQ-037 ENTRIES=16: allocate 0x40 then taken update at 0x80 (same index, different tag) -> 0x40 misses, 0x80 hits.
REQ-038 Update 0x40 and lookup 0x40 same cycle -> old prediction that cycle, new next; clear_i with simultaneous update -> no entry valid afterwards.
REQ-039 CNT_W=4: 20 mispredicting updates -> both counters stop at 15.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg -- shared definitions for the branch predictor.
//   ctr_t       : 2-bit saturating direction counter states (SNT/WNT/WT/ST)
//   BP_ENTRIES  : default number of direct-mapped predictor entries
//   BP_ADDR_W   : storage width of the tag/target fields in bp_entry_t
//   bp_entry_t  : stored per-entry record (valid, tag, target); the direction
//                 counter of each entry lives in its own sat_counter2
// ---------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int BP_ENTRIES = 16;
  localparam int BP_ADDR_W  = 32;

  // Tags are stored zero-extended to BP_ADDR_W so one record type serves any
  // ENTRIES setting; constant-zero upper tag bits are trimmed by synthesis.
  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2 -- 2-bit saturating direction counter for one predictor entry.
//   clk, rst : clock, asynchronous active-high reset (state -> SNT)
//   inc      : step towards ST, saturating
//   dec      : step towards SNT, saturating
//   load     : force WT (new allocation); has priority over inc/dec
//   state    : current counter state
// ---------------------------------------------------------------------------
module sat_counter2
  import bp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic load,
  output ctr_t state
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SNT;
    end else if (load) begin
      state <= WT;
    end else if (inc && state != ST) begin
      state <= ctr_t'(state + 2'd1);
    end else if (dec && state != SNT) begin
      state <= ctr_t'(state - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor -- direct-mapped branch target predictor with 2-bit
// direction counters and saturating statistics.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   pc_i                  : fetch address looked up combinationally
//   pred_taken_o          : predicted taken for pc_i
//   pred_target_o         : predicted target (0 when not predicted taken)
//   upd_valid_i           : a resolved branch/jump is reported this cycle
//   upd_pc_i, upd_taken_i, upd_target_i : resolved instruction and outcome
//   upd_pred_taken_i, upd_pred_target_i : prediction carried down the pipe
//   clear_i               : synchronous invalidate of every entry
//   mispredict_o          : combinational outcome/prediction mismatch
//   branch_cnt_o, mispred_cnt_o : saturating statistics counters
// ADDR_W must not exceed bp_pkg::BP_ADDR_W.
// ---------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              clear_i,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  typedef logic [IDX_W-1:0] idx_t;

  bp_entry_t entry [ENTRIES];
  ctr_t      ctr   [ENTRIES];

  // Word-aligned PC: bits [1:0] are dropped, the next IDX_W bits index.
  function automatic logic [BP_ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return BP_ADDR_W'(pc >> (IDX_W + 2));
  endfunction

  // ---------------- lookup (reads pre-update contents) ----------------
  idx_t lk_idx;
  logic lk_hit;

  assign lk_idx        = pc_i[IDX_W+1:2];
  assign lk_hit        = entry[lk_idx].valid && (entry[lk_idx].tag == tag_of(pc_i));
  assign pred_taken_o  = lk_hit && (ctr[lk_idx] == WT || ctr[lk_idx] == ST);
  assign pred_target_o = pred_taken_o ? entry[lk_idx].target[ADDR_W-1:0] : '0;

  // ---------------- update ----------------
  idx_t upd_idx;
  logic upd_hit;
  logic wr_en;

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_hit = entry[upd_idx].valid && (entry[upd_idx].tag == tag_of(upd_pc_i));
  // clear_i discards a coincident update entirely.
  assign wr_en   = upd_valid_i && !clear_i;

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_target_i)));

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
    logic sel;
    assign sel = wr_en && (upd_idx == idx_t'(gi));

    sat_counter2 u_ctr (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (sel && upd_hit && upd_taken_i),
      .dec   (sel && upd_hit && !upd_taken_i),
      .load  (sel && !upd_hit && upd_taken_i),
      .state (ctr[gi])
    );
  end

  // NOTE: the entry array is flop-based with async reset because tags and
  // targets must read back as 0 straight out of reset; it cannot map to RAM.
  // A taken update writes the same record on hit (tag unchanged, new target)
  // and on miss (allocation, replacing whatever occupied the index).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) entry[i].valid <= 1'b0;
    end else if (wr_en && upd_taken_i) begin
      entry[upd_idx] <= '{valid:  1'b1,
                          tag:    tag_of(upd_pc_i),
                          target: BP_ADDR_W'(upd_target_i)};
    end
  end

  // ---------------- statistics (saturate at all-ones) ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (upd_valid_i && branch_cnt_o != '1)
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (mispredict_o && mispred_cnt_o != '1)
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor -- directed bench for branch_predictor. A default
// instance (CNT_W=32) and a narrow-statistics instance (CNT_W=4) share all
// inputs; the narrow one is only inspected for reset and saturation.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        clear;

  logic        pred_taken,  pred_taken4;
  logic [31:0] pred_target, pred_target4;
  logic        mispredict,  mispredict4;
  logic [31:0] branch_cnt,  mispred_cnt;
  logic [3:0]  branch_cnt4, mispred_cnt4;

  int vectors     = 0;
  int miscompares = 0;
  int exp_br      = 0;
  int exp_mp      = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .clear_i(clear),
    .mispredict_o(mispredict), .branch_cnt_o(branch_cnt),
    .mispred_cnt_o(mispred_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .pred_taken_o(pred_taken4), .pred_target_o(pred_target4),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .clear_i(clear),
    .mispredict_o(mispredict4), .branch_cnt_o(branch_cnt4),
    .mispred_cnt_o(mispred_cnt4)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; clear = 1'b0;
  endtask

  task automatic check_lookup(input string name, input logic [31:0] addr,
                              input logic exp_taken, input logic [31:0] exp_target);
    pc = addr;
    #1;
    vectors++;
    if (pred_taken !== exp_taken || pred_target !== exp_target) begin
      miscompares++;
      $display("FAIL %s: pc=%h got taken=%b target=%h, expected taken=%b target=%h",
               name, addr, pred_taken, pred_target, exp_taken, exp_target);
    end
  endtask

  task automatic check_stats(input string name);
    vectors++;
    if (branch_cnt !== 32'(exp_br) || mispred_cnt !== 32'(exp_mp)) begin
      miscompares++;
      $display("FAIL %s: got branch=%0d mispred=%0d, expected branch=%0d mispred=%0d",
               name, branch_cnt, mispred_cnt, exp_br, exp_mp);
    end
  endtask

  // One update cycle; exp_mis is the hand-derived mispredict value.
  task automatic do_update(input string name, input logic [31:0] a, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt, input logic exp_mis);
    upd_valid = 1'b1; upd_pc = a; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    vectors++;
    if (mispredict !== exp_mis) begin
      miscompares++;
      $display("FAIL %s mispredict: got %b expected %b", name, mispredict, exp_mis);
    end
    exp_br++;
    if (exp_mis) exp_mp++;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    pc  = 32'h40;
    // Mispredict is purely combinational on the update inputs, even in reset.
    upd_valid = 1'b1; upd_taken = 1'b1; upd_target = 32'h80;
    #1;
    vectors++;
    if (mispredict !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mispredict: got %b expected 1", mispredict);
    end
    step();
    idle_inputs();
    check_lookup("reset_lookup", 32'h40, 1'b0, 32'h0);
    check_stats("reset_stats");
    vectors++;
    if (branch_cnt4 !== 4'd0 || mispred_cnt4 !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_stats4: got %0d/%0d expected 0/0", branch_cnt4, mispred_cnt4);
    end
    rst = 1'b0;
    step();
    check_lookup("post_reset_lookup", 32'h40, 1'b0, 32'h0);
  endtask

  task automatic test_allocate();
    pc = 32'h40;
    do_update("alloc", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    check_lookup("alloc_lookup", 32'h40, 1'b1, 32'h80);
    check_stats("alloc_stats");
  endtask

  task automatic test_counter();
    // WT -> WNT -> SNT -> SNT
    do_update("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    check_lookup("nt1_lookup", 32'h40, 1'b0, 32'h0);
    do_update("nt2", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_update("nt3", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // SNT -> WNT: still not taken proves SNT held rather than wrapping.
    do_update("t1", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    check_lookup("t1_lookup", 32'h40, 1'b0, 32'h0);
    do_update("t2", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    check_lookup("t2_lookup", 32'h40, 1'b1, 32'h80);
    do_update("t3", 32'h40, 1'b1, 32'h84, 1'b1, 32'h80, 1'b1);
    check_lookup("t3_target_overwrite", 32'h40, 1'b1, 32'h84);
    do_update("t4", 32'h40, 1'b1, 32'h88, 1'b1, 32'h88, 1'b0);
    // ST held: one not-taken leaves WT (taken), the next gives WNT.
    do_update("nt4", 32'h40, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1);
    check_lookup("st_saturate", 32'h40, 1'b1, 32'h88);
    do_update("nt5", 32'h40, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1);
    check_lookup("wt_to_wnt", 32'h40, 1'b0, 32'h0);
    check_stats("counter_stats");
  endtask

  task automatic test_alias();
    // 0x40 and 0x80 share index 0 with different tags.
    do_update("alias_alloc", 32'h80, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    check_lookup("alias_old_miss", 32'h40, 1'b0, 32'h0);
    check_lookup("alias_new_hit", 32'h80, 1'b1, 32'h100);
    check_lookup("low_bits_ignored", 32'h83, 1'b1, 32'h100);
    // Not-taken miss must not disturb the resident entry.
    do_update("nt_miss", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_lookup("nt_miss_no_change", 32'h80, 1'b1, 32'h100);
  endtask

  task automatic test_same_cycle_and_clear();
    pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b0;
    upd_pred_taken = 1'b1; upd_pred_target = 32'h100;
    #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      miscompares++;
      $display("FAIL same_cycle_old: got %b/%h expected 1/00000100", pred_taken, pred_target);
    end
    vectors++;
    if (mispredict !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_mispredict: got %b expected 1", mispredict);
    end
    exp_br++; exp_mp++;
    step();
    idle_inputs();
    check_lookup("same_cycle_new", 32'h80, 1'b0, 32'h0);

    do_update("alloc_44", 32'h44, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    check_lookup("alloc_44_hit", 32'h44, 1'b1, 32'h300);
    // Clear with a taken update to 0x80 (WNT, would become WT) in the same cycle.
    clear = 1'b1;
    do_update("clear_upd", 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    check_lookup("clear_80", 32'h80, 1'b0, 32'h0);
    check_lookup("clear_44", 32'h44, 1'b0, 32'h0);
    check_stats("clear_keeps_stats");
  endtask

  task automatic test_async_reset_mid_update();
    do_update("pre_rst", 32'h48, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    upd_valid = 1'b1; upd_pc = 32'h4C; upd_taken = 1'b1; upd_target = 32'h500;
    #2;
    rst = 1'b1;
    #1;
    exp_br = 0; exp_mp = 0;
    check_stats("async_rst_stats");
    check_lookup("async_rst_48", 32'h48, 1'b0, 32'h0);
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    check_lookup("rst_update_lost", 32'h4C, 1'b0, 32'h0);
    check_stats("post_rst_stats");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      do_update("sat", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
      if (i == 14) begin
        vectors++;
        if (branch_cnt4 !== 4'd15 || mispred_cnt4 !== 4'd15) begin
          miscompares++;
          $display("FAIL sat_reach15: got %0d/%0d expected 15/15", branch_cnt4, mispred_cnt4);
        end
      end
    end
    vectors++;
    if (branch_cnt4 !== 4'd15 || mispred_cnt4 !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_hold15: got %0d/%0d expected 15/15", branch_cnt4, mispred_cnt4);
    end
    check_stats("sat_wide_20");
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle_and_clear();
    test_async_reset_mid_update();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
